alu_word_sequencer: RTL and testbench
=====================================

# alu_word_sequencer

Multi-cycle controller that performs NIBBLES×4-bit add, subtract, AND and OR by driving the team's combinational 4-bit ALU slice one nibble per cycle. It chains the carry through a register and assembles the wide result. It sits directly upstream of the 4-bit ALU:
- It feeds the ALU's a, b, opcode and cin inputs.
- It consumes the ALU's result and cout.
- It presents a valid/ready command and result interface to the datapath controller above it.

## Interface
- NIBBLES, default 4: number of 4-bit slices. Word width W = 4*NIBBLES. Legal values are 1 to 8.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation: 00 add, 01 sub (a-b), 10 AND, 11 OR. The encoding matches the ALU opcode.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- alu_a  out  4  nibble of A for the ALU slice.
- alu_b  out  4  nibble of B for the ALU slice.
- alu_opcode  out  2  opcode for the ALU slice.
- alu_cin  out  1  carry into the ALU slice.
- alu_result  in  4  ALU slice result (combinational from alu_*).
- alu_cout  in  1  ALU slice carry out. Ignored for opcodes 10/11.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  W  assembled result.
- out_carry  out  1  final carry. For sub, 1 = no borrow. Always 0 for AND/OR.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[W-1].
- out_ovf  out  1  signed overflow for add/sub. Always 0 for AND/OR.

## Operation
- State machine has three states: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE**
  - cmd_ready=1.
  - When cmd_valid=1 at the edge: capture cmd_op, cmd_a, cmd_b; set idx=0; load carry_reg; go to RUN.
  - carry_reg loads 1 for sub and 0 otherwise.
- **RUN**
  - cmd_ready=0.
  - Drive alu_a=a_reg[4*idx+3:4*idx], alu_b=b_reg nibble idx, alu_opcode=op_reg, alu_cin=carry_reg.
  - The block does not invert B; the ALU inverts B for opcode 01.
  - Each edge: write alu_result into res_reg nibble idx; carry_reg<=alu_cout (add/sub only); idx<=idx+1.
  - At the edge where idx==NIBBLES-1: go to DONE.
- **DONE**
  - out_valid=1; all out_* are stable.
  - When out_ready=1 at the edge: go to IDLE.
  - No command is accepted in the same cycle the result is taken.
- Outside RUN: alu_a=0, alu_b=0, alu_cin=0, alu_opcode=op_reg.
- Flag computation, with sa=a_reg[W-1], sb=b_reg[W-1], sr=res_reg[W-1]:
  - add: out_ovf = (sa==sb)&&(sr!=sa).
  - sub: out_ovf = (sa!=sb)&&(sr!=sa).
  - out_carry = carry_reg for add/sub.
  - out_zero and out_neg apply to all ops.
- Arithmetic is modulo 2^W. There is no carry-in from outside; an add always starts with carry 0.
- Changes on cmd_* while not in IDLE are ignored.
- Reset asserted mid-RUN or mid-DONE:
  - Immediately (asynchronously) returns to IDLE.
  - Clears a_reg, b_reg, res_reg, carry_reg, op_reg and idx.
  - The in-flight command is discarded with no output.

## Timing
- Reset values:
  - cmd_ready=1, out_valid=0, out_result=0.
  - All flags 0.
  - alu_a=0, alu_b=0, alu_opcode=00, alu_cin=0.
- Latency: if a command is accepted at edge E0, out_valid rises after edge E0+NIBBLES.
- Minimum occupancy is NIBBLES+2 cycles per command (accept, NIBBLES RUN cycles, one DONE cycle with out_ready=1). Back-to-back throughput is one command per NIBBLES+2 cycles.
- out_valid is held, with all out_* unchanged, for as long as out_ready=0.
- cmd_ready and out_valid are pure decodes of state. They do not depend combinationally on cmd_valid or out_ready.
- The ALU path is combinational within one cycle: alu_* are registered-state decodes, and alu_result/alu_cout are sampled at the next edge.

## Test plan
Bench uses NIBBLES=4 with the team's alu_4bit connected to the alu_* ports.
- **Add wrap:** add 0xFFFF + 0x0001 -> out_result=0x0000, carry=1, zero=1, neg=0, ovf=0. out_valid rises exactly 4 edges after accept.
- **Signed overflow:** add 0x7FFF + 0x0001 -> 0x8000, neg=1, ovf=1, carry=0.
- **Subtract:**
  - sub 0x0005 - 0x0007 -> 0xFFFE, carry=0, neg=1, ovf=0.
  - sub 0x1234 - 0x1234 -> 0x0000, carry=1, zero=1.
- **Logic ops:**
  - AND 0xF0F0, 0x3C3C -> 0x3030, carry=0, ovf=0.
  - OR 0x0F00, 0x00F0 -> 0x0FF0.
- **Backpressure:** hold out_ready=0 for 3 cycles in DONE -> out_valid and out_* are unchanged, cmd_ready=0, and a cmd_valid pulse is ignored. On release the handshake completes, and cmd_ready=1 the next cycle.
- **Reset mid-operation:** assert rst_n=0 two cycles into RUN -> immediately cmd_ready=1, out_valid=0, alu_*=0. After release, a new add 0x0002 + 0x0003 -> 0x0005 with correct flags.

Source files
------------

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs NIBBLES x 4-bit add/sub/AND/OR through an external 4-bit ALU slice.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o         command handshake; cmd_op_i (00 add, 01 sub, 10 and, 11 or), cmd_a_i, cmd_b_i
//   alu_a_o/alu_b_o/alu_opcode_o/alu_cin_o   drive to the ALU slice
//   alu_result_i/alu_cout_i         combinational return from the ALU slice
//   out_valid_o/out_ready_i         result handshake; out_result_o plus carry/zero/neg/ovf flags
module alu_word_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [4*NIBBLES-1:0]   cmd_a_i,
    input  logic [4*NIBBLES-1:0]   cmd_b_i,
    output logic [3:0]             alu_a_o,
    output logic [3:0]             alu_b_o,
    output logic [1:0]             alu_opcode_o,
    output logic                   alu_cin_o,
    input  logic [3:0]             alu_result_i,
    input  logic                   alu_cout_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [4*NIBBLES-1:0]   out_result_o,
    output logic                   out_carry_o,
    output logic                   out_zero_o,
    output logic                   out_neg_o,
    output logic                   out_ovf_o
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            run, done, arith, sa, sb, sr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (cmd_valid_i) begin
                op_d    = cmd_op_i;
                a_d     = cmd_a_i;
                b_d     = cmd_b_i;
                idx_d   = '0;
                // sub starts with carry 1: the ALU adds ~b, so this completes the two's complement
                carry_d = cmd_op_i == 2'b01;
                state_d = RUN;
            end
            RUN: begin
                res_d[{idx_q, 2'b00} +: 4] = alu_result_i;
                carry_d = op_q[1] ? carry_q : alu_cout_i;
                idx_d   = idx_q + 1'b1;
                state_d = idx_q == LAST ? DONE : RUN;
            end
            DONE: state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign run          = state_q == RUN;
    assign done         = state_q == DONE;
    assign cmd_ready_o  = state_q == IDLE;
    assign out_valid_o  = done;
    assign alu_a_o      = run ? a_q[{idx_q, 2'b00} +: 4] : 4'h0;
    assign alu_b_o      = run ? b_q[{idx_q, 2'b00} +: 4] : 4'h0;
    assign alu_cin_o    = run & carry_q;
    assign alu_opcode_o = op_q;
    assign arith        = ~op_q[1];
    assign sa           = a_q[W-1];
    assign sb           = b_q[W-1];
    assign sr           = res_q[W-1];
    assign out_result_o = res_q;
    // flags are only meaningful while a result is presented; held low otherwise
    assign out_carry_o  = done & arith & carry_q;
    assign out_zero_o   = done & (res_q == '0);
    assign out_neg_o    = done & sr;
    assign out_ovf_o    = done & arith & (op_q[0] ? (sa != sb) : (sa == sb)) & (sr != sa);
endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb_alu_word_sequencer: random and directed check of alu_word_sequencer with a 4-bit ALU slice model.
module tb_alu_word_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, out_valid, out_ready;
    logic [1:0]  cmd_op, alu_opcode;
    logic [15:0] cmd_a, cmd_b, out_result;
    logic [3:0]  alu_a, alu_b, alu_result;
    logic        alu_cin, alu_cout, out_carry, out_zero, out_neg, out_ovf;
    logic [4:0]  alu_sum;
    int          n_tests = 0;
    int          n_fail = 0;
    always #5 clk = ~clk;
    alu_word_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_opcode), .alu_cin_o(alu_cin),
        .alu_result_i(alu_result), .alu_cout_i(alu_cout),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
        .out_carry_o(out_carry), .out_zero_o(out_zero), .out_neg_o(out_neg), .out_ovf_o(out_ovf)
    );
    // 4-bit ALU slice: sub adds the inverted B plus carry-in
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
            2'b01:   alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
            2'b10:   alu_sum = {1'b0, alu_a & alu_b};
            default: alu_sum = {1'b0, alu_a | alu_b};
        endcase
    end
    assign alu_result = alu_sum[3:0];
    assign alu_cout   = alu_sum[4];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // word-level reference using plain integer arithmetic
    task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic c, output logic z,
                         output logic n, output logic v);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin
                r = a + b;
                c = (int'(a) + int'(b)) > 65535;
                s = sa + sb;
                v = s > 32767 || s < -32768;
            end
            2'b01: begin
                r = a - b;
                c = a >= b;
                s = sa - sb;
                v = s > 32767 || s < -32768;
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        z = r == 16'h0;
        n = r[15];
    endtask
    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] er;
        logic        ec, ez, en, ev;
        int          k;
        model(op, a, b, er, ec, ez, en, ev);
        check("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_a     = 16'($urandom);
        cmd_b     = 16'($urandom);
        check("ready_run", 32'(cmd_ready), 32'd0);
        check("alu_a_n0", 32'(alu_a), 32'(a[3:0]));
        check("alu_b_n0", 32'(alu_b), 32'(b[3:0]));
        check("alu_cin_n0", 32'(alu_cin), 32'(op == 2'b01));
        check("alu_op_run", 32'(alu_opcode), 32'(op));
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'd4);
        check("result", 32'(out_result), 32'(er));
        check("carry", 32'(out_carry), 32'(ec));
        check("zero", 32'(out_zero), 32'(ez));
        check("neg", 32'(out_neg), 32'(en));
        check("ovf", 32'(out_ovf), 32'(ev));
        check("ready_done", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom);
            cmd_a     = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'(out_result), 32'(er));
            check("hold_flags", {28'd0, out_carry, out_zero, out_neg, out_ovf}, {28'd0, ec, ez, en, ev});
            check("hold_ready", 32'(cmd_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        cmd_valid = 1'b0;
        check("taken_valid", 32'(out_valid), 32'd0);
        check("taken_ready", 32'(cmd_ready), 32'd1);
    endtask
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = 16'h0;
        cmd_b     = 16'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_flags", {28'd0, out_carry, out_zero, out_neg, out_ovf}, 32'd0);
        check("rst_alu", {21'd0, alu_a, alu_b, alu_opcode, alu_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_cmd(2'b00, 16'hFFFF, 16'h0001, 0);
        do_cmd(2'b00, 16'h7FFF, 16'h0001, 0);
        do_cmd(2'b01, 16'h0005, 16'h0007, 0);
        do_cmd(2'b01, 16'h1234, 16'h1234, 0);
        do_cmd(2'b10, 16'hF0F0, 16'h3C3C, 0);
        do_cmd(2'b11, 16'h0F00, 16'h00F0, 0);
        do_cmd(2'b00, 16'h1111, 16'h2222, 3);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_a     = 16'hABCD;
        cmd_b     = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_alu", {21'd0, alu_a, alu_b, alu_opcode, alu_cin}, 32'd0);
        check("mid_rst_result", 32'(out_result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_cmd(2'b00, 16'h0002, 16'h0003, 0);
        for (int t = 0; t < 40; t++)
            do_cmd(2'($urandom), pick(), pick(), int'($urandom_range(0, 2)));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
